// File: rtl/fib_disp.sv
`default_nettype none
// =====================================================================
// Module   : fib_disp
// Purpose  : Captures the BCD Fibonacci result on the done pulse and
//            scans it onto a common-anode 4-digit seven-segment display.
// Revision : 1.0
// =====================================================================
module fib_disp #(
    parameter int REFRESH_W = 18,
    parameter int BLINK_W   = 24
) (
    input  logic       iCLK,
    input  logic       iRESET_N,
    input  logic       iSTART,
    input  logic       iDONE,
    input  logic       iOFLOW,
    input  logic [3:0] iBCD3,
    input  logic [3:0] iBCD2,
    input  logic [3:0] iBCD1,
    input  logic [3:0] iBCD0,
    output logic [3:0] oAN,
    output logic [7:0] oSEG,
    output logic [1:0] oMODE
);

    localparam logic [1:0] C_ST_BLANK = 2'd0;
    localparam logic [1:0] C_ST_WAIT  = 2'd1;
    localparam logic [1:0] C_ST_SHOW  = 2'd2;
    localparam logic [1:0] C_ST_OFLOW = 2'd3;

    localparam logic [7:0] C_SEG_OFF  = 8'hFF;
    localparam logic [7:0] C_SEG_DASH = 8'hBF;

    localparam logic [REFRESH_W-1:0] C_SCAN_ONE  = 1;
    localparam logic [BLINK_W-1:0]   C_BLINK_ONE = 1;

    logic [1:0]           state_q, state_d;
    logic [3:0]           d3_q, d3_d;
    logic [3:0]           d2_q, d2_d;
    logic [3:0]           d1_q, d1_d;
    logic [3:0]           d0_q, d0_d;
    logic                 ovf_q, ovf_d;
    logic [REFRESH_W-1:0] scan_q, scan_d;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic [3:0]           an_q, an_d;
    logic [7:0]           seg_q, seg_d;

    logic [1:0]           sel;
    logic [3:0]           digit;
    logic                 lead_blank;

    function automatic logic [7:0] seg_code(input logic [3:0] value);
        case (value)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return C_SEG_OFF;
        endcase
    endfunction

    // State register plus capture, counter and output flops.
    always_ff @(posedge iCLK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            state_q <= C_ST_BLANK;
            d3_q    <= 4'd0;
            d2_q    <= 4'd0;
            d1_q    <= 4'd0;
            d0_q    <= 4'd0;
            ovf_q   <= 1'b0;
            scan_q  <= '0;
            blink_q <= '0;
            an_q    <= 4'hF;
            seg_q   <= C_SEG_OFF;
        end else begin
            state_q <= state_d;
            d3_q    <= d3_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
            ovf_q   <= ovf_d;
            scan_q  <= scan_d;
            blink_q <= blink_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    // Next state: a done pulse wins over a same-cycle start.
    always_comb begin
        state_d = state_q;
        if (iDONE) begin
            state_d = iOFLOW ? C_ST_OFLOW : C_ST_SHOW;
        end else if (iSTART) begin
            state_d = C_ST_WAIT;
        end
    end

    always_comb begin
        d3_d    = d3_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        ovf_d   = ovf_q;
        scan_d  = scan_q + C_SCAN_ONE;
        blink_d = '0;
        if (iDONE) begin
            d3_d  = iBCD3;
            d2_d  = iBCD2;
            d1_d  = iBCD1;
            d0_d  = iBCD0;
            ovf_d = iOFLOW;
        end
        // Any entry into OFLOW restarts the blink on its visible phase.
        if (!(iDONE && iOFLOW) && state_q == C_ST_OFLOW) begin
            blink_d = blink_q + C_BLINK_ONE;
        end
    end

    // Output decode, registered so oAN/oSEG lag state and scan by one cycle.
    always_comb begin
        sel        = scan_q[REFRESH_W-1 -: 2];
        digit      = d0_q;
        lead_blank = 1'b0;
        case (sel)
            2'd0: begin
                digit      = d0_q;
                lead_blank = 1'b0;
            end
            2'd1: begin
                digit      = d1_q;
                lead_blank = (d3_q == 4'd0) && (d2_q == 4'd0) && (d1_q == 4'd0);
            end
            2'd2: begin
                digit      = d2_q;
                lead_blank = (d3_q == 4'd0) && (d2_q == 4'd0);
            end
            default: begin
                digit      = d3_q;
                lead_blank = (d3_q == 4'd0);
            end
        endcase

        an_d = ~(4'b0001 << sel);

        case (state_q)
            C_ST_BLANK: seg_d = C_SEG_OFF;
            C_ST_WAIT:  seg_d = C_SEG_DASH;
            C_ST_SHOW:  seg_d = lead_blank ? C_SEG_OFF : seg_code(digit);
            default:    seg_d = (ovf_q && !blink_q[BLINK_W-1]) ? C_SEG_DASH : C_SEG_OFF;
        endcase
    end

    assign oAN   = an_q;
    assign oSEG  = seg_q;
    assign oMODE = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_disp.sv
`default_nettype none
// =====================================================================
// Module   : tb_fib_disp
// Purpose  : Self-checking bench for fib_disp against a behavioural model.
// Revision : 1.0
// =====================================================================
module tb_fib_disp;

    localparam int RW       = 4;
    localparam int BW       = 6;
    localparam int DIG_CYC  = 2 ** (RW - 2);
    localparam int BLINK_HP = 2 ** (BW - 1);

    logic       iCLK;
    logic       iRESET_N;
    logic       iSTART;
    logic       iDONE;
    logic       iOFLOW;
    logic [3:0] iBCD3, iBCD2, iBCD1, iBCD0;
    logic [3:0] oAN;
    logic [7:0] oSEG;
    logic [1:0] oMODE;

    int total = 0;
    int bad   = 0;

    int         m_edges;
    int         m_ent;
    int         m_mode;
    logic [3:0] m_d [4];
    logic [7:0] seg_tab [16];
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [1:0] exp_mode;

    fib_disp #(.REFRESH_W(RW), .BLINK_W(BW)) dut (
        .iCLK     (iCLK),
        .iRESET_N (iRESET_N),
        .iSTART   (iSTART),
        .iDONE    (iDONE),
        .iOFLOW   (iOFLOW),
        .iBCD3    (iBCD3),
        .iBCD2    (iBCD2),
        .iBCD1    (iBCD1),
        .iBCD0    (iBCD0),
        .oAN      (oAN),
        .oSEG     (oSEG),
        .oMODE    (oMODE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic reset_model();
        m_edges  = 0;
        m_ent    = 0;
        m_mode   = 0;
        for (int k = 0; k < 4; k++) m_d[k] = 4'd0;
        exp_an   = 4'hF;
        exp_seg  = 8'hFF;
        exp_mode = 2'd0;
    endtask

    // What digit position pos should show given the model's current view.
    function automatic logic [7:0] model_seg(int pos);
        bit lead;
        case (m_mode)
            0: return 8'hFF;
            1: return 8'hBF;
            3: return ((((m_edges - m_ent) / BLINK_HP) % 2) == 0) ? 8'hBF : 8'hFF;
            default: begin
                lead = (pos != 0);
                for (int k = 3; k >= pos; k--) if (m_d[k] != 4'd0) lead = 0;
                return lead ? 8'hFF : seg_tab[m_d[pos]];
            end
        endcase
    endfunction

    // Advance one clock, update the model, return at the following negedge.
    task automatic step();
        int pos;
        @(posedge iCLK);
        pos            = (m_edges / DIG_CYC) % 4;
        exp_an         = 4'hF;
        exp_an[pos]    = 1'b0;
        exp_seg        = model_seg(pos);
        m_edges++;
        if (iDONE) begin
            m_d[3] = iBCD3; m_d[2] = iBCD2; m_d[1] = iBCD1; m_d[0] = iBCD0;
            m_mode = iOFLOW ? 3 : 2;
            if (iOFLOW) m_ent = m_edges;
        end else if (iSTART) begin
            m_mode = 1;
        end
        exp_mode = 2'(m_mode);
        @(negedge iCLK);
    endtask

    task automatic set_in(input logic s, input logic d, input logic o,
                          input logic [3:0] b3, input logic [3:0] b2,
                          input logic [3:0] b1, input logic [3:0] b0);
        iSTART = s; iDONE = d; iOFLOW = o;
        iBCD3 = b3; iBCD2 = b2; iBCD1 = b1; iBCD0 = b0;
    endtask

    // Idle cycle: no events, but the data inputs wander to prove they are ignored.
    task automatic idle_in();
        set_in(1'b0, 1'b0, 1'($urandom), 4'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom));
    endtask

    task automatic test_reset(input string tag);
        for (int i = 0; i < 7; i++) begin
            idle_in();
            step();
            total++; if (oAN !== exp_an) begin bad++; $display("FAIL %s pre an: got %b want %b", tag, oAN, exp_an); end
            total++; if (oSEG !== exp_seg) begin bad++; $display("FAIL %s pre seg: got %h want %h", tag, oSEG, exp_seg); end
        end
        #2 iRESET_N = 1'b0;
        #1;
        total++; if (oAN !== 4'hF) begin bad++; $display("FAIL %s async an: got %b want 1111", tag, oAN); end
        total++; if (oSEG !== 8'hFF) begin bad++; $display("FAIL %s async seg: got %h want ff", tag, oSEG); end
        total++; if (oMODE !== 2'd0) begin bad++; $display("FAIL %s async mode: got %0d want 0", tag, oMODE); end
        reset_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            total++; if (oAN !== 4'hF || oSEG !== 8'hFF || oMODE !== 2'd0) begin
                bad++; $display("FAIL %s held: got an=%b seg=%h mode=%0d want 1111/ff/0", tag, oAN, oSEG, oMODE);
            end
        end
        iRESET_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle_in();
            step();
            total++; if (oAN !== exp_an) begin bad++; $display("FAIL %s post an: got %b want %b", tag, oAN, exp_an); end
            total++; if (oSEG !== exp_seg) begin bad++; $display("FAIL %s post seg: got %h want %h", tag, oSEG, exp_seg); end
            total++; if (oMODE !== exp_mode) begin bad++; $display("FAIL %s post mode: got %0d want %0d", tag, oMODE, exp_mode); end
        end
    endtask

    task automatic test_full_result();
        for (int i = 0; i < 24; i++) begin
            if (i == 0) set_in(1'b0, 1'b1, 1'b0, 4'd6, 4'd7, 4'd6, 4'd5);
            else        idle_in();
            step();
            total++; if (oAN !== exp_an) begin bad++; $display("FAIL full an: got %b want %b", oAN, exp_an); end
            total++; if (oSEG !== exp_seg) begin bad++; $display("FAIL full seg: got %h want %h", oSEG, exp_seg); end
            total++; if (oMODE !== exp_mode) begin bad++; $display("FAIL full mode: got %0d want %0d", oMODE, exp_mode); end
        end
    endtask

    task automatic test_leading_zero();
        for (int i = 0; i < 44; i++) begin
            if (i == 0)       set_in(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 4'd3);
            else if (i == 22) set_in(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
            else              idle_in();
            step();
            total++; if (oAN !== exp_an) begin bad++; $display("FAIL lzb an: got %b want %b", oAN, exp_an); end
            total++; if (oSEG !== exp_seg) begin bad++; $display("FAIL lzb seg: got %h want %h", oSEG, exp_seg); end
            total++; if (oMODE !== exp_mode) begin bad++; $display("FAIL lzb mode: got %0d want %0d", oMODE, exp_mode); end
        end
    endtask

    task automatic test_overflow_blink();
        for (int i = 0; i < 260; i++) begin
            if (i == 0 || i == 170) set_in(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
            else if (i == 20 || i == 180) set_in(1'b0, 1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
            else idle_in();
            step();
            total++; if (oAN !== exp_an) begin bad++; $display("FAIL blink an: got %b want %b", oAN, exp_an); end
            total++; if (oSEG !== exp_seg) begin bad++; $display("FAIL blink seg: got %h want %h", oSEG, exp_seg); end
            total++; if (oMODE !== exp_mode) begin bad++; $display("FAIL blink mode: got %0d want %0d", oMODE, exp_mode); end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 60; i++) begin
            if (i == 0)       set_in(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
            else if (i == 20) set_in(1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 4'd5, 4'd5);
            else if (i == 30) set_in(1'b1, 1'b0, 1'b0, 4'd8, 4'd8, 4'd8, 4'd8);
            else if (i == 35) set_in(1'b1, 1'b1, 1'b0, 4'd0, 4'd8, 4'd0, 4'd2);
            else              idle_in();
            step();
            total++; if (oAN !== exp_an) begin bad++; $display("FAIL simul an: got %b want %b", oAN, exp_an); end
            total++; if (oSEG !== exp_seg) begin bad++; $display("FAIL simul seg: got %h want %h", oSEG, exp_seg); end
            total++; if (oMODE !== exp_mode) begin bad++; $display("FAIL simul mode: got %0d want %0d", oMODE, exp_mode); end
        end
    endtask

    task automatic test_invalid_digit();
        for (int i = 0; i < 24; i++) begin
            if (i == 0) set_in(1'b0, 1'b1, 1'b0, 4'hA, 4'd0, 4'd0, 4'd3);
            else        idle_in();
            step();
            total++; if (oAN !== exp_an) begin bad++; $display("FAIL invalid an: got %b want %b", oAN, exp_an); end
            total++; if (oSEG !== exp_seg) begin bad++; $display("FAIL invalid seg: got %h want %h", oSEG, exp_seg); end
            total++; if (oMODE !== exp_mode) begin bad++; $display("FAIL invalid mode: got %0d want %0d", oMODE, exp_mode); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            idle_in();
            if ($urandom_range(29, 0) == 0) iSTART = 1'b1;
            if ($urandom_range(39, 0) == 0) begin
                iDONE = 1'b1;
                // Bias digits toward zero so leading-zero blanking gets exercised.
                if ($urandom_range(1, 0) == 0) iBCD3 = 4'd0;
                if ($urandom_range(2, 0) == 0) iBCD2 = 4'd0;
                if ($urandom_range(3, 0) == 0) iBCD1 = 4'd0;
            end
            step();
            total++; if (oAN !== exp_an) begin bad++; $display("FAIL random an: got %b want %b", oAN, exp_an); end
            total++; if (oSEG !== exp_seg) begin bad++; $display("FAIL random seg: got %h want %h", oSEG, exp_seg); end
            total++; if (oMODE !== exp_mode) begin bad++; $display("FAIL random mode: got %0d want %0d", oMODE, exp_mode); end
        end
    endtask

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        iRESET_N = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        reset_model();
        repeat (3) @(negedge iCLK);
        iRESET_N = 1'b1;

        test_reset("reset");
        test_full_result();
        test_leading_zero();
        test_overflow_blink();
        set_in(1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
        step();
        for (int i = 0; i < 40; i++) begin
            idle_in();
            step();
        end
        test_reset("blink_rst");
        test_simultaneous();
        test_invalid_digit();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
